fifo_sync_flags: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the basic byte FIFO.

---
 rtl/fifo_sync_flags.sv | 105 ++++++++++
 tb/tb_fifo_sync_flags.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise reads have 1-cycle latency.
module fifo_sync_flags #(
    parameter int unsigned SIZE_DATA    = 8,
    parameter int unsigned SIZE_DEPTH   = 16,
    parameter int unsigned AFULL_LEVEL  = 12,
    parameter int unsigned AEMPTY_LEVEL = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic                          i_clr_err,
    input  logic                          i_wr_en,
    input  logic [SIZE_DATA-1:0]          i_data,
    input  logic                          i_rd_en,
    output logic [SIZE_DATA-1:0]          o_data,
    output logic                          o_valid,
    output logic                          o_fifo_full,
    output logic                          o_fifo_empty,
    output logic                          o_almost_full,
    output logic                          o_almost_empty,
    output logic [$clog2(SIZE_DEPTH):0]   o_count,
    output logic                          o_err_overflow,
    output logic                          o_err_underflow
);

    localparam int unsigned SIZE_ADDR = $clog2(SIZE_DEPTH);
    localparam logic [SIZE_ADDR:0] AFULL_CNT  = (SIZE_ADDR + 1)'(AFULL_LEVEL);
    localparam logic [SIZE_ADDR:0] AEMPTY_CNT = (SIZE_ADDR + 1)'(AEMPTY_LEVEL);

    logic [SIZE_DATA-1:0] mem [SIZE_DEPTH];
    logic [SIZE_ADDR:0]   wr_ptr;
    logic [SIZE_ADDR:0]   rd_ptr;
    logic [SIZE_ADDR:0]   count;
    logic                 full;
    logic                 empty;
    logic                 wr_accept;
    logic                 rd_accept;
    logic                 ovf_set;
    logic                 unf_set;

    // Extra MSB on each pointer distinguishes full from empty when the low bits match.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[SIZE_ADDR-1:0] == rd_ptr[SIZE_ADDR-1:0]) &&
                    (wr_ptr[SIZE_ADDR] != rd_ptr[SIZE_ADDR]);
        count     = wr_ptr - rd_ptr;
        wr_accept = i_wr_en & ~full & ~i_flush;
        rd_accept = i_rd_en & ~empty & ~i_flush;
        ovf_set   = i_wr_en & full & ~i_flush;
        unf_set   = i_rd_en & empty & ~i_flush;
    end

    assign o_fifo_full    = full;
    assign o_fifo_empty   = empty;
    assign o_count        = count;
    assign o_almost_full  = (count >= AFULL_CNT);
    assign o_almost_empty = (count <= AEMPTY_CNT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_accept) mem[wr_ptr[SIZE_ADDR-1:0]] <= i_data;
    end

    // A new error event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err_overflow  <= 1'b0;
            o_err_underflow <= 1'b0;
        end else begin
            if (ovf_set)        o_err_overflow <= 1'b1;
            else if (i_clr_err) o_err_overflow <= 1'b0;
            if (unf_set)        o_err_underflow <= 1'b1;
            else if (i_clr_err) o_err_underflow <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    assign o_data  = mem[rd_ptr[SIZE_ADDR-1:0]];
    assign o_valid = ~empty;
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= rd_accept;
            if (rd_accept) o_data <= mem[rd_ptr[SIZE_ADDR-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags at depth 8, thresholds 6/2; follows FIFO_FWFT_EN if defined.
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rdata;
    logic       valid;
    logic       full;
    logic       empty;
    logic       afull;
    logic       aempty;
    logic [3:0] count;
    logic       err_ovf;
    logic       err_unf;

    int tests = 0;
    int fails = 0;

    fifo_sync_flags #(
        .SIZE_DATA   (8),
        .SIZE_DEPTH  (8),
        .AFULL_LEVEL (6),
        .AEMPTY_LEVEL(2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_flush        (flush),
        .i_clr_err      (clr_err),
        .i_wr_en        (wr_en),
        .i_data         (wdata),
        .i_rd_en        (rd_en),
        .o_data         (rdata),
        .o_valid        (valid),
        .o_fifo_full    (full),
        .o_fifo_empty   (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_count        (count),
        .o_err_overflow (err_ovf),
        .o_err_underflow(err_unf)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (aempty !== 1'b1) begin fails++; $display("FAIL reset_aempty got %b want 1", aempty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
        tests++; if (afull !== 1'b0) begin fails++; $display("FAIL reset_afull got %b want 0", afull); end
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if ({err_ovf, err_unf} !== 2'b00) begin
            fails++; $display("FAIL reset_errs got %b want 00", {err_ovf, err_unf});
        end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
`ifndef FIFO_FWFT_EN
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", rdata); end
`endif
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wdata = 8'(i);
            step();
            tests++; if (count !== 4'(i)) begin fails++; $display("FAIL fill_count got %0d want %0d", count, i); end
            tests++; if (afull !== (i >= 6)) begin fails++; $display("FAIL fill_afull@%0d got %b", i, afull); end
            tests++; if (full !== (i == 8)) begin fails++; $display("FAIL fill_full@%0d got %b", i, full); end
            tests++; if (aempty !== (i <= 2)) begin fails++; $display("FAIL fill_aempty@%0d got %b", i, aempty); end
        end
        wr_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_FWFT_EN
            tests++; if (rdata !== 8'(i) || valid !== 1'b1) begin
                fails++; $display("FAIL drain_data got %h/%b want %h/1", rdata, valid, 8'(i));
            end
            rd_en = 1'b1;
            step();
`else
            rd_en = 1'b1;
            step();
            tests++; if (rdata !== 8'(i) || valid !== 1'b1) begin
                fails++; $display("FAIL drain_data got %h/%b want %h/1", rdata, valid, 8'(i));
            end
`endif
            tests++; if (count !== 4'(8 - i)) begin
                fails++; $display("FAIL drain_count got %0d want %0d", count, 8 - i);
            end
        end
        rd_en = 1'b0;
        step();
        tests++; if (valid !== 1'b0 || empty !== 1'b1) begin
            fails++; $display("FAIL drain_idle got valid=%b empty=%b want 0/1", valid, empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wdata = 8'h10 + 8'(i);
            step();
        end
        wdata = 8'hAA;
        step();
        tests++; if (count !== 4'd8) begin fails++; $display("FAIL ovf_count got %0d want 8", count); end
        tests++; if (err_ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", err_ovf); end
        clr_err = 1'b1;
        step();
        tests++; if (err_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set_wins got %b want 1", err_ovf); end
        wr_en = 1'b0;
        step();
        clr_err = 1'b0;
        tests++; if (err_ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b want 0", err_ovf); end
`ifdef FIFO_FWFT_EN
        tests++; if (rdata !== 8'h10) begin fails++; $display("FAIL ovf_head got %h want 10", rdata); end
        rd_en = 1'b1;
        step();
`else
        rd_en = 1'b1;
        step();
        tests++; if (rdata !== 8'h10) begin fails++; $display("FAIL ovf_head got %h want 10", rdata); end
`endif
        rd_en = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_underflow();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL unf_pre_empty got %b want 1", empty); end
        rd_en = 1'b1; wr_en = 1'b1; wdata = 8'h55;
        step();
        wr_en = 1'b0;
        tests++; if (count !== 4'd1) begin fails++; $display("FAIL unf_count got %0d want 1", count); end
        tests++; if (err_unf !== 1'b1) begin fails++; $display("FAIL unf_flag got %b want 1", err_unf); end
`ifdef FIFO_FWFT_EN
        tests++; if (rdata !== 8'h55 || valid !== 1'b1) begin
            fails++; $display("FAIL unf_read got %h/%b want 55/1", rdata, valid);
        end
        step();
`else
        tests++; if (rdata !== 8'h10 || valid !== 1'b0) begin
            fails++; $display("FAIL unf_hold got %h/%b want 10/0", rdata, valid);
        end
        step();
        tests++; if (rdata !== 8'h55 || valid !== 1'b1) begin
            fails++; $display("FAIL unf_read got %h/%b want 55/1", rdata, valid);
        end
`endif
        rd_en = 1'b0;
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL unf_after got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wdata = 8'h30 + 8'(i);
            step();
        end
        for (int j = 0; j < 20; j++) begin
            wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h34 + 8'(j);
`ifdef FIFO_FWFT_EN
            tests++; if (rdata !== 8'h30 + 8'(j)) begin
                fails++; $display("FAIL b2b_data got %h want %h", rdata, 8'h30 + 8'(j));
            end
            step();
`else
            step();
            tests++; if (rdata !== 8'h30 + 8'(j)) begin
                fails++; $display("FAIL b2b_data got %h want %h", rdata, 8'h30 + 8'(j));
            end
`endif
            tests++; if (count !== 4'd4) begin fails++; $display("FAIL b2b_count got %0d want 4", count); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_flush_reset();
        wr_en = 1'b1; wdata = 8'h50;
        step();
        tests++; if (count !== 4'd5) begin fails++; $display("FAIL flush_pre got %0d want 5", count); end
        flush = 1'b1; wdata = 8'h51;
        step();
        flush = 1'b0; wr_en = 1'b0;
        tests++; if (count !== 4'd0 || empty !== 1'b1) begin
            fails++; $display("FAIL flush_count got %0d/%b want 0/1", count, empty);
        end
        tests++; if ({err_ovf, err_unf} !== 2'b01) begin
            fails++; $display("FAIL flush_errs got %b want 01", {err_ovf, err_unf});
        end
`ifndef FIFO_FWFT_EN
        tests++; if (rdata !== 8'h43) begin fails++; $display("FAIL flush_hold got %h want 43", rdata); end
`endif
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; rd_en = (i == 2); wdata = 8'h60 + 8'(i);
            step();
        end
        #2 rst = 1'b1;
        #1;
        tests++; if (count !== 4'd0 || empty !== 1'b1 || aempty !== 1'b1) begin
            fails++; $display("FAIL rst_mid got count=%0d empty=%b aempty=%b", count, empty, aempty);
        end
        tests++; if ({full, afull, valid, err_ovf, err_unf} !== 5'b0) begin
            fails++; $display("FAIL rst_mid_flags got %b want 00000", {full, afull, valid, err_ovf, err_unf});
        end
`ifndef FIFO_FWFT_EN
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL rst_mid_data got %h want 00", rdata); end
`endif
        wr_en = 1'b0; rd_en = 1'b0;
        step();
        rst = 1'b0;
        step();
        tests++; if (count !== 4'd0 || empty !== 1'b1) begin
            fails++; $display("FAIL rst_release got %0d/%b want 0/1", count, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_flush_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
